load_store_unit: RTL and testbench

Initiator side of the data-memory port: accepts one load or store at a time from the execute stage and drives `data_memory` (addr, write_data, funct3, mem_read, mem_write, read_data). It checks alignment and range, sequences the single-cycle memory access, then lane-selects and sign- or zero-extends load data. It sits between the pipeline's MEM stage and `data_memory`, and returns a completion response for every accepted request.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/load_extend.sv | 27 ++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 codes, LSU state encoding,
// the request payload, and small decode helpers.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned F3_BITS = 3;

  localparam logic [F3_BITS-1:0] F3_B  = 3'b000;
  localparam logic [F3_BITS-1:0] F3_H  = 3'b001;
  localparam logic [F3_BITS-1:0] F3_W  = 3'b010;
  localparam logic [F3_BITS-1:0] F3_BU = 3'b100;
  localparam logic [F3_BITS-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_WAIT   = 2'd2,
    LSU_RESP   = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic               is_store;
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    wdata;
    logic [F3_BITS-1:0] funct3;
  } lsu_req_t;

  // Access width in bytes; only meaningful for legal funct3 values.
  function automatic logic [2:0] access_size(input logic [F3_BITS-1:0] funct3);
    case (funct3[1:0])
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

  // Stores only have signed encodings (SB/SH/SW).
  function automatic logic funct3_legal(input logic [F3_BITS-1:0] funct3,
                                        input logic               is_store);
    case (funct3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = !is_store;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane-selects a byte or half from a raw memory word and sign/zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0]    i_word,
  input  logic [1:0]         i_addr_lo,
  input  logic [F3_BITS-1:0] i_funct3,
  output logic [XLEN-1:0]    o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = 8'(i_word >> {i_addr_lo, 3'b000});
    w_half   = 16'(i_word >> {i_addr_lo[1], 4'b0000});
    o_data_c = i_word;
    case (i_funct3)
      F3_B:    o_data_c = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data_c = {24'h000000, w_byte};
      F3_H:    o_data_c = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data_c = {16'h0000, w_half};
      default: o_data_c = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: validates one load/store at a time, sequences the
// single-cycle memory access and returns a response per accepted request.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_store,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [F3_BITS-1:0]  req_funct3,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [F3_BITS-1:0]  mem_funct3,
  output logic                mem_read,
  output logic                mem_write,
  input  logic [XLEN-1:0]     mem_rdata
);

  lsu_state_e         r_state, w_next_state;
  lsu_req_t           r_req, w_next_req, w_in_req;
  logic               r_req_ready, w_nxt_req_ready;
  logic               r_rsp_valid, w_nxt_rsp_valid;
  logic               r_rsp_err, w_nxt_rsp_err;
  logic [XLEN-1:0]    r_rsp_rdata, w_nxt_rsp_rdata;
  logic [XLEN-1:0]    r_mem_addr, w_nxt_mem_addr;
  logic [XLEN-1:0]    r_mem_wdata, w_nxt_mem_wdata;
  logic [F3_BITS-1:0] r_mem_funct3, w_nxt_mem_funct3;
  logic               r_mem_read, w_nxt_mem_read;
  logic               r_mem_write, w_nxt_mem_write;

  logic               w_accept;
  logic [XLEN:0]      w_end;
  logic               w_range_err, w_align_err, w_f3_err, w_req_err;
  logic [XLEN-1:0]    w_ext_data;

  assign w_in_req = '{is_store: req_is_store, addr: req_addr,
                      wdata: req_wdata, funct3: req_funct3};
  assign w_accept = r_req_ready && req_valid;

  // Range check in XLEN+1 bits so addresses near the top do not wrap.
  assign w_end       = {1'b0, req_addr} + (XLEN+1)'(access_size(req_funct3));
  assign w_range_err = w_end > (XLEN+1)'(MEM_BYTES);
  assign w_align_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_f3_err    = !funct3_legal(req_funct3, req_is_store);
  assign w_req_err   = w_range_err || w_align_err || w_f3_err;

  load_extend u_load_extend (
    .i_word    (mem_rdata),
    .i_addr_lo (r_req.addr[1:0]),
    .i_funct3  (r_req.funct3),
    .o_data_c  (w_ext_data)
  );

  // Next state plus next value of every registered output.
  always_comb begin
    w_next_state     = r_state;
    w_next_req       = r_req;
    w_nxt_req_ready  = 1'b0;
    w_nxt_rsp_valid  = 1'b0;
    w_nxt_rsp_err    = 1'b0;
    w_nxt_rsp_rdata  = '0;
    w_nxt_mem_addr   = '0;
    w_nxt_mem_wdata  = '0;
    w_nxt_mem_funct3 = '0;
    w_nxt_mem_read   = 1'b0;
    w_nxt_mem_write  = 1'b0;

    case (r_state)
      LSU_IDLE: begin
        if (w_accept) begin
          w_next_req   = w_in_req;
          w_next_state = w_req_err ? LSU_RESP : LSU_ACCESS;
        end
      end
      LSU_ACCESS: w_next_state = r_req.is_store ? LSU_RESP : LSU_WAIT;
      LSU_WAIT:   w_next_state = LSU_RESP;
      LSU_RESP:   if (rsp_ready) w_next_state = LSU_IDLE;
      default:    w_next_state = LSU_IDLE;
    endcase

    w_nxt_req_ready = (w_next_state == LSU_IDLE);

    if ((w_next_state == LSU_ACCESS) || (w_next_state == LSU_WAIT)) begin
      w_nxt_mem_addr   = w_next_req.addr;
      w_nxt_mem_wdata  = w_next_req.wdata;
      w_nxt_mem_funct3 = w_next_req.funct3;
      w_nxt_mem_read   = !w_next_req.is_store;
      w_nxt_mem_write  = (w_next_state == LSU_ACCESS) && w_next_req.is_store;
    end

    if (w_next_state == LSU_RESP) begin
      w_nxt_rsp_valid = 1'b1;
      case (r_state)
        LSU_IDLE: w_nxt_rsp_err   = 1'b1;
        LSU_WAIT: w_nxt_rsp_rdata = w_ext_data;
        LSU_RESP: begin
          w_nxt_rsp_err   = r_rsp_err;
          w_nxt_rsp_rdata = r_rsp_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LSU_IDLE;
      r_req        <= '0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_funct3 <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_req        <= w_next_req;
      r_req_ready  <= w_nxt_req_ready;
      r_rsp_valid  <= w_nxt_rsp_valid;
      r_rsp_err    <= w_nxt_rsp_err;
      r_rsp_rdata  <= w_nxt_rsp_rdata;
      r_mem_addr   <= w_nxt_mem_addr;
      r_mem_wdata  <= w_nxt_mem_wdata;
      r_mem_funct3 <= w_nxt_mem_funct3;
      r_mem_read   <= w_nxt_mem_read;
      r_mem_write  <= w_nxt_mem_write;
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_funct3 = r_mem_funct3;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array data memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem [0:4095] = '{default: 8'h00};
  logic [11:0] w_wa;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Little-endian data memory: raw word at addr[31:2], byte-granular writes.
  assign w_wa = {mem_addr[11:2], 2'b00};
  assign mem_rdata = {mem[w_wa + 12'd3], mem[w_wa + 12'd2], mem[w_wa + 12'd1], mem[w_wa]};

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[11:0]] <= mem_wdata[7:0];
      if (mem_funct3 != 3'b000) mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
        mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
      end
    end
  end

  // Presents a request for exactly one rising edge (the accept edge N).
  task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_addr = a; req_wdata = d; req_funct3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                          output logic vld, output logic er);
    issue(1'b1, a, d, f3);
    repeat (2) @(negedge clk);
    vld = rsp_valid; er = rsp_err;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3,
                         output logic vld, output logic [31:0] rd, output logic er);
    issue(1'b0, a, 32'h0, f3);
    repeat (3) @(negedge clk);
    vld = rsp_valid; rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, mem_read, mem_write, rsp_err} !== 5'b0 || rsp_rdata !== 32'h0)
      $display("FAIL reset_outputs: got rdy=%b vld=%b rd=%b wr=%b err=%b rdata=%h, want all 0",
               req_ready, rsp_valid, mem_read, mem_write, rsp_err, rsp_rdata);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_store_load();
    logic vld, er;
    logic [31:0] rd;
    issue(1'b1, 32'h0, 32'hDEADBEEF, 3'b010);
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hDEADBEEF || mem_funct3 !== 3'b010)
      $display("FAIL sw_access: got wr=%b addr=%h wdata=%h f3=%b want 1/0/deadbeef/010",
               mem_write, mem_addr, mem_wdata, mem_funct3);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL sw_resp: got wr=%b vld=%b err=%b rdata=%h want 0/1/0/0",
               mem_write, rsp_valid, rsp_err, rsp_rdata);
    else n_pass++;

    issue(1'b0, 32'h0, 32'h0, 3'b010);
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h0 || rsp_valid !== 1'b0)
      $display("FAIL lw_n1: got rd=%b addr=%h vld=%b want 1/0/0", mem_read, mem_addr, rsp_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h0 || rsp_valid !== 1'b0)
      $display("FAIL lw_n2: got rd=%b addr=%h vld=%b want 1/0/0", mem_read, mem_addr, rsp_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || mem_read !== 1'b0)
      $display("FAIL lw_n3: got vld=%b rdata=%h err=%b rd=%b want 1/deadbeef/0/0",
               rsp_valid, rsp_rdata, rsp_err, mem_read);
    else n_pass++;

    do_store(32'h0, 32'h000000FF, 3'b000, vld, er);
    do_load(32'h0, 3'b010, vld, rd, er);
    n_checks++;
    if (vld !== 1'b1 || rd !== 32'hDEADBEFF || er !== 1'b0)
      $display("FAIL sb_merge: got vld=%b rdata=%h err=%b want 1/deadbeff/0", vld, rd, er);
    else n_pass++;

    do_store(32'h2, 32'h00001234, 3'b001, vld, er);
    do_load(32'h0, 3'b010, vld, rd, er);
    n_checks++;
    if (rd !== 32'h1234BEFF || er !== 1'b0)
      $display("FAIL sh_merge: got rdata=%h err=%b want 1234beff/0", rd, er);
    else n_pass++;
  endtask

  task automatic test_lanes();
    logic [31:0] addrs [5] = '{32'd7, 32'd7, 32'd6, 32'd4, 32'd4};
    logic [2:0]  f3s   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] exps  [5] = '{32'hFFFFFFCA, 32'h000000CA, 32'hFFFFCAFE, 32'h0000BABE, 32'hFFFFFFBE};
    logic vld, er;
    logic [31:0] rd;
    do_store(32'h4, 32'hCAFEBABE, 3'b010, vld, er);
    n_checks++;
    if (vld !== 1'b1 || er !== 1'b0) $display("FAIL sw4_resp: got vld=%b err=%b want 1/0", vld, er);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      do_load(addrs[i], f3s[i], vld, rd, er);
      n_checks++;
      if (vld !== 1'b1 || rd !== exps[i] || er !== 1'b0)
        $display("FAIL lane_%0d: got vld=%b rdata=%h err=%b want 1/%h/0", i, vld, rd, er, exps[i]);
      else n_pass++;
    end
    do_load(32'd4092, 3'b010, vld, rd, er);
    n_checks++;
    if (vld !== 1'b1 || rd !== 32'h0 || er !== 1'b0)
      $display("FAIL lw_top_word: got vld=%b rdata=%h err=%b want 1/0/0", vld, rd, er);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic        sts   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] addrs [6] = '{32'd2, 32'd1, 32'd4094, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [2:0]  f3s   [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b000, 3'b100};
    for (int i = 0; i < 6; i++) begin
      issue(sts[i], addrs[i], 32'hFFFFFFFF, f3s[i]);
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 ||
          mem_read !== 1'b0 || mem_write !== 1'b0)
        $display("FAIL err_%0d: got vld=%b err=%b rdata=%h rd=%b wr=%b want 1/1/0/0/0",
                 i, rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || rsp_valid !== 1'b0)
        $display("FAIL err_%0d_idle: got rdy=%b rd=%b wr=%b vld=%b want 1/0/0/0",
                 i, req_ready, mem_read, mem_write, rsp_valid);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic vld, er;
    logic [31:0] rd;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0, 32'h0, 3'b010);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234BEFF || req_ready !== 1'b0 || mem_write !== 1'b0)
        $display("FAIL stall_%0d: got vld=%b rdata=%h rdy=%b wr=%b want 1/1234beff/0/0",
                 i, rsp_valid, rsp_rdata, req_ready, mem_write);
      else n_pass++;
      if (i == 0) begin
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = 32'd8;
        req_wdata = 32'h55555555; req_funct3 = 3'b010;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL stall_release: got rdy=%b vld=%b wr=%b want 1/0/0", req_ready, rsp_valid, mem_write);
    else n_pass++;
    do_load(32'd8, 3'b010, vld, rd, er);
    n_checks++;
    if (vld !== 1'b1 || rd !== 32'h0 || er !== 1'b0)
      $display("FAIL stall_ignored_req: got vld=%b rdata=%h err=%b want 1/0/0", vld, rd, er);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    logic vld, er;
    logic [31:0] rd;
    issue(1'b0, 32'h4, 32'h0, 3'b010);
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h4)
      $display("FAIL wait_before_rst: got rd=%b addr=%h want 1/4", mem_read, mem_addr);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write, rsp_valid, req_ready, rsp_err} !== 5'b0 || mem_addr !== 32'h0 || rsp_rdata !== 32'h0)
      $display("FAIL rst_mid_wait: got rd=%b wr=%b vld=%b rdy=%b err=%b addr=%h rdata=%h want all 0",
               mem_read, mem_write, rsp_valid, req_ready, rsp_err, mem_addr, rsp_rdata);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", req_ready);
    else n_pass++;
    do_load(32'h4, 3'b010, vld, rd, er);
    n_checks++;
    if (vld !== 1'b1 || rd !== 32'hCAFEBABE || er !== 1'b0)
      $display("FAIL lw_after_rst: got vld=%b rdata=%h err=%b want 1/cafebabe/0", vld, rd, er);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_lanes();
    test_errors();
    test_stall();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
